// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_DEF     = 8;
    localparam int W_DEF     = 8;
    localparam int BURST_DEF = 4;

    // Index of the set bit in a one-hot vector; returns 0 for an all-zero vector.
    function automatic int unsigned oh2idx(input logic [63:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority pick: first set request at or above the pointer, wrapping to bit 0.
module rr_pick #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] win,
    output logic         found
);

    logic [N-1:0] masked;
    logic [N-1:0] pool;

    always_comb begin
        // Requests at or above the pointer position take precedence.
        masked = req & ~(ptr - N'(1));
        pool   = (|masked) ? masked : req;
        win    = pool & (~pool + N'(1));
        found  = |req;
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// N:1 round-robin arbiter with burst-bounded ownership and a one-hot priority ring.
// Optional ARB_LOCK_EN adds a lock input that suspends burst expiry for the owner.
module rr_burst_arbiter
    import arb_pkg::*;
#(
    parameter  int N     = N_DEF,
    parameter  int W     = W_DEF,
    parameter  int BURST = BURST_DEF,
    localparam int IW    = $clog2(N),
    localparam int CW    = $clog2(BURST) + 1
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] in_data,
`ifdef ARB_LOCK_EN
    input  logic           lock,
`endif
    output logic [N-1:0]   gnt,
    output logic [IW-1:0]  gnt_idx,
    output logic           gnt_valid,
    output logic [W-1:0]   out_data,
    output logic [N-1:0]   ptr
);

    state_t        state, state_nxt;
    logic [N-1:0]  gnt_nxt, ptr_nxt;
    logic [IW-1:0] idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [N-1:0]  win;
    logic          found;
    logic          hold_ok;
    logic          owner_req;

    rr_pick #(.N(N)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .win   (win),
        .found (found)
    );

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            ptr     <= N'(1);
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= idx_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        idx_nxt   = gnt_idx;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        hold_ok   = 1'b0;
`ifdef ARB_LOCK_EN
        hold_ok   = lock;
`endif
        owner_req = req[gnt_idx];

        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt   = win;
                    idx_nxt   = IW'(oh2idx(64'(win)));
                    cnt_nxt   = CW'(BURST - 1);
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // Release rotates the ring so the old owner drops to lowest priority.
                if (!owner_req || (cnt == '0 && !hold_ok)) begin
                    gnt_nxt   = '0;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    ptr_nxt   = {gnt[N-2:0], gnt[N-1]};
                    state_nxt = IDLE;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    assign gnt_valid = |gnt;

    always_comb begin
        out_data = '0;
        if (gnt_valid) out_data = in_data[int'(gnt_idx)*W +: W];
    end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Randomized bench for rr_burst_arbiter against an ownership/turn-order reference model.
module tb_rr_burst_arbiter;

    localparam int N     = 8;
    localparam int W     = 8;
    localparam int BURST = 4;
    localparam int IW    = $clog2(N);

    logic           clk = 1'b0;
    logic           clr_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] in_data;
    logic           lock;
    logic [N-1:0]   gnt;
    logic [IW-1:0]  gnt_idx;
    logic           gnt_valid;
    logic [W-1:0]   out_data;
    logic [N-1:0]   ptr;

    int checks = 0;
    int errors = 0;

    // Reference model: current owner (-1 = none), cycles owned so far, priority position.
    int owner = -1;
    int held  = 0;
    int pidx  = 0;
    bit lock_en;

    always #5 clk = ~clk;

    rr_burst_arbiter #(.N(N), .W(W), .BURST(BURST)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .req       (req),
        .in_data   (in_data),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .out_data  (out_data),
        .ptr       (ptr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic c, input logic [N-1:0] r, input logic l);
        if (!c) begin
            owner = -1;
            held  = 0;
            pidx  = 0;
        end else if (owner < 0) begin
            for (int i = 0; i < N; i++) begin
                if (owner < 0 && r[(pidx + i) % N]) begin
                    owner = (pidx + i) % N;
                    held  = 1;
                end
            end
        end else if (!r[owner] || (held >= BURST && !(lock_en && l))) begin
            pidx  = (owner + 1) % N;
            owner = -1;
            held  = 0;
        end else begin
            held++;
        end
    endtask

    task automatic compare_all();
        logic [N-1:0]  e_gnt;
        logic [IW-1:0] e_idx;
        logic [W-1:0]  e_data;
        e_gnt  = (owner >= 0) ? N'(1) << owner : '0;
        e_idx  = (owner >= 0) ? IW'(owner) : '0;
        e_data = (owner >= 0) ? in_data[owner*W +: W] : '0;
        check("gnt",       64'(gnt),       64'(e_gnt));
        check("gnt_idx",   64'(gnt_idx),   64'(e_idx));
        check("gnt_valid", 64'(gnt_valid), 64'(owner >= 0));
        check("ptr",       64'(ptr),       64'(N'(1) << pidx));
        check("out_data",  64'(out_data),  64'(e_data));
    endtask

    task automatic step(input logic c, input logic [N-1:0] r, input logic l);
        clr_n = c;
        req   = r;
        lock  = l;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
        @(posedge clk);
        model_edge(c, r, l);
        #1;
        compare_all();
    endtask

    initial begin
`ifdef ARB_LOCK_EN
        lock_en = 1'b1;
`else
        lock_en = 1'b0;
`endif
        clr_n = 1'b0; req = '0; lock = 1'b0; in_data = '0;

        // Reset with all requests asserted.
        step(1'b0, 8'hFF, 1'b0);
        step(1'b0, 8'hFF, 1'b0);
        check("reset_ptr", 64'(ptr), 64'h01);
        step(1'b1, 8'hFF, 1'b0);
        check("first_gnt", 64'(gnt), 64'h01);
        step(1'b0, 8'h00, 1'b0);

        // Burst limit on a single requester.
        for (int i = 0; i < 12; i++) step(1'b1, 8'h08, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Wrap fairness between requesters 0 and 7.
        for (int i = 0; i < 16; i++) step(1'b1, 8'h81, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Early release by requester 5.
        step(1'b1, 8'h20, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        check("early_ptr", 64'(ptr), 64'h40);
        step(1'b1, 8'h00, 1'b0);

        // Reset in the middle of a grant.
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h04, 1'b0);
        step(1'b1, 8'h04, 1'b0);
        step(1'b0, 8'h04, 1'b0);
        check("midreset_gnt", 64'(gnt), 64'h00);

`ifdef ARB_LOCK_EN
        // Lock holds owner 1 past its burst.
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h12, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 8'h12, 1'b1);
        check("lock_hold", 64'(gnt), 64'h02);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h12, 1'b0);
`endif

        // Randomized traffic with occasional reset and lock.
        for (int i = 0; i < 2000; i++) begin
            logic [N-1:0] r;
            r = N'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & N'($urandom);
            if ($urandom_range(0, 5) == 0) r = '0;
            step(($urandom_range(0, 60) != 0), r, 1'($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- Round-robin arbiter that shares one W-bit output channel (an N:1 data mux) among N requesters.
- Priority pointer is a one-hot ring counter; a burst down-counter bounds how long an owner may hold the channel.
- Sits in front of a shared downstream datapath/counter; drives its select and qualifies its data.

Parameters:
N, 8, number of requesters (>=2)
W, 8, data width per requester
BURST, 4, max consecutive grant cycles per ownership (>=1)
IW (localparam), $clog2(N), grant index width
CW (localparam), $clog2(BURST)+1, burst counter width

Ports:
clk  input  1  clock, all logic on posedge
clr_n  input  1  synchronous active-low reset
req  input  N  request vector, bit i = requester i
in_data  input  N*W  requester data, requester i at [i*W +: W]
lock  input  1  hold current grant (present only with ARB_LOCK_EN)
gnt  output  N  one-hot grant, registered
gnt_idx  output  IW  binary index of granted requester, registered
gnt_valid  output  1  any grant active (= |gnt)
out_data  output  W  in_data slice selected by gnt_idx when gnt_valid, else 0
ptr  output  N  one-hot priority pointer (debug/observability)

Behaviour:
- One clock; reset synchronous active-low: on posedge with clr_n=0 -> state IDLE, gnt=0, gnt_idx=0, gnt_valid=0, ptr={N-1'b0,1'b1}, burst cnt=0; out_data=0. Applies mid-grant too; no grant in the reset cycle's successor unless req seen after reset release.
- FSM states: IDLE, GRANT.
- IDLE: if |req, winner = first set req bit searching from ptr position upward, wrapping N-1 -> 0; next cycle gnt=onehot(winner), gnt_idx=winner, cnt=BURST-1, -> GRANT. Latency req->gnt = 1 cycle. If req=0 stay IDLE.
- GRANT, owner o: release when req[o]=0 OR cnt==0; else cnt<=cnt-1, hold gnt.
- Release: gnt<=0, -> IDLE, ptr<=onehot((o+1) mod N) (ring rotate, wrap to bit 0). Exactly one dead cycle between ownerships; arbitration in that IDLE cycle uses updated ptr.
- Max hold = BURST cycles with req held; owner still requesting re-competes at lowest priority after rotation.
- Requests from non-owners during GRANT ignored (no preemption).
- ptr changes only on release; IDLE with no requests does not rotate.
- out_data combinational from registered gnt_idx/gnt_valid; no X when idle.
- Invariant: gnt always zero or one-hot; gnt_valid==|gnt; gnt_idx matches gnt.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined: lock port exists; in GRANT with lock=1 and req[o]=1, burst expiry suppressed (cnt holds at 0, grant held); req[o]=0 still releases. lock ignored in IDLE.
- Undefined: no lock port; burst limit always enforced.

Decomposition:
- Package arb_pkg: state enum typedef (IDLE, GRANT), default N/W/BURST constants, onehot-to-index function.
- Sub-module rr_pick: combinational rotating priority pick (req, ptr -> one-hot winner, found flag); arbiter instantiates it once.

Test Plan:
- Reset: clr_n=0 two cycles with req=8'hFF -> gnt=0, gnt_valid=0, ptr=8'h01, out_data=0; after clr_n=1, next cycle gnt=8'h01.
- Burst limit: req=8'h08 held 12 cycles, BURST=4 -> gnt=8'h08 for 4 cycles, 0 for 1, 8'h08 again; gnt_idx=3, out_data=in_data[31:24] while granted.
- Wrap fairness: req=8'h81 held, ptr=8'h01 -> grant 0 (4 cyc), ptr=8'h02, grant 7, ptr=8'h01, grant 0.
- Early release: grant req[5] alone, drop req[5] after 2 granted cycles -> gnt=0 next edge, ptr=8'h40, state IDLE.
- Reset mid-grant: clr_n=0 during 2nd cycle of grant to 2 -> next edge gnt=0, ptr=8'h01, cnt=0.
- ARB_LOCK_EN: req=8'h12, lock=1 on owner 1 for 7 cycles -> gnt=8'h02 held 7 cycles; lock=0 -> release, next grant 8'h10.
